// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: two request ports plus the shared read-data return.
// Valid/ready: reqN is held with its fields until the one-cycle gntN; rvalidN/errN close the access.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req0;
   logic              req1;
   logic              we0;
   logic              we1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic              gnt0;
   logic              gnt1;
   logic              rvalid0;
   logic              rvalid1;
   logic              err0;
   logic              err1;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      input  gnt0, gnt1, rvalid0, rvalid1, err0, err1, rdata
   );

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      output gnt0, gnt1, rvalid0, rvalid1, err0, err1, rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one data memory (registered one-cycle read) between two requesters,
// with round-robin or fixed-priority arbitration and out-of-range rejection.
module dmem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int DEPTH      = 128,
   parameter int FIXED_PRIO = 0
) (
   input  logic              clk,
   input  logic              reset,
   dmem_arbiter_if.slave     bus,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RDATA = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);

   state_t            state, state_n;
   logic              last_grant, last_grant_n;
   logic              owner, owner_n;
   logic              gnt0, gnt0_n, gnt1, gnt1_n;
   logic              err0, err0_n, err1, err1_n;
   logic [ADDR_W-1:0] addr_n;
   logic [DATA_W-1:0] wdata_n;
   logic              write_n, read_n;

   logic              pick1;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   // Requester 1 wins alone, or on a tie when round-robin says it is its turn.
   assign pick1     = bus.req1 && (!bus.req0 || (FIXED_PRIO == 0 && !last_grant));
   assign sel_we    = pick1 ? bus.we1    : bus.we0;
   assign sel_addr  = pick1 ? bus.addr1  : bus.addr0;
   assign sel_wdata = pick1 ? bus.wdata1 : bus.wdata0;

   always_comb begin
      state_n      = state;
      last_grant_n = last_grant;
      owner_n      = owner;
      addr_n       = mem_addr;
      wdata_n      = mem_wdata;
      write_n      = 1'b0;
      read_n       = 1'b0;
      gnt0_n       = 1'b0;
      gnt1_n       = 1'b0;
      err0_n       = 1'b0;
      err1_n       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               last_grant_n = pick1;
               gnt0_n       = !pick1;
               gnt1_n       = pick1;
               if (sel_addr >= LIMIT) begin
                  err0_n = !pick1;
                  err1_n = pick1;
               end else begin
                  owner_n = pick1;
                  addr_n  = sel_addr;
                  wdata_n = sel_wdata;
                  write_n = sel_we;
                  read_n  = !sel_we;
                  state_n = ISSUE;
               end
            end
         end
         ISSUE:   state_n = mem_read ? RDATA : IDLE;
         RDATA:   state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
         err0       <= 1'b0;
         err1       <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_write  <= 1'b0;
         mem_read   <= 1'b0;
      end else begin
         state      <= state_n;
         last_grant <= last_grant_n;
         owner      <= owner_n;
         gnt0       <= gnt0_n;
         gnt1       <= gnt1_n;
         err0       <= err0_n;
         err1       <= err1_n;
         mem_addr   <= addr_n;
         mem_wdata  <= wdata_n;
         mem_write  <= write_n;
         mem_read   <= read_n;
      end
   end

   // Memory data arrives one cycle after mem_read, which is exactly the RDATA cycle.
   assign bus.rvalid0 = (state == RDATA) && !owner;
   assign bus.rvalid1 = (state == RDATA) && owner;
   assign bus.rdata   = mem_rdata;
   assign bus.gnt0    = gnt0;
   assign bus.gnt1    = gnt1;
   assign bus.err0    = err0;
   assign bus.err1    = err1;
   assign dbg_state   = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin and a fixed-priority instance share
// identical stimulus, each backed by its own registered-read memory model.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1, we0, we1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_rr ();
   dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_fp ();

   logic [31:0] mem_addr_rr, mem_wdata_rr, mem_rdata_rr;
   logic [31:0] mem_addr_fp, mem_wdata_fp, mem_rdata_fp;
   logic        mem_write_rr, mem_read_rr, mem_write_fp, mem_read_fp;
   logic [1:0]  state_rr, state_fp;
   logic [31:0] mem_rr [128];
   logic [31:0] mem_fp [128];

   assign bus_rr.req0 = req0;     assign bus_fp.req0 = req0;
   assign bus_rr.req1 = req1;     assign bus_fp.req1 = req1;
   assign bus_rr.we0 = we0;       assign bus_fp.we0 = we0;
   assign bus_rr.we1 = we1;       assign bus_fp.we1 = we1;
   assign bus_rr.addr0 = addr0;   assign bus_fp.addr0 = addr0;
   assign bus_rr.addr1 = addr1;   assign bus_fp.addr1 = addr1;
   assign bus_rr.wdata0 = wdata0; assign bus_fp.wdata0 = wdata0;
   assign bus_rr.wdata1 = wdata1; assign bus_fp.wdata1 = wdata1;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(128), .FIXED_PRIO(0)) u_rr (
      .clk(clk), .reset(reset), .bus(bus_rr),
      .mem_addr(mem_addr_rr), .mem_wdata(mem_wdata_rr), .mem_write(mem_write_rr),
      .mem_read(mem_read_rr), .mem_rdata(mem_rdata_rr), .dbg_state(state_rr)
   );

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(128), .FIXED_PRIO(1)) u_fp (
      .clk(clk), .reset(reset), .bus(bus_fp),
      .mem_addr(mem_addr_fp), .mem_wdata(mem_wdata_fp), .mem_write(mem_write_fp),
      .mem_read(mem_read_fp), .mem_rdata(mem_rdata_fp), .dbg_state(state_fp)
   );

   initial begin
      for (int i = 0; i < 128; i++) begin
         mem_rr[i] = '0;
         mem_fp[i] = '0;
      end
      mem_rdata_rr = '0;
      mem_rdata_fp = '0;
   end

   // Word-addressed memory, write and registered read sampled on the same edge.
   always @(posedge clk) begin
      if (mem_write_rr) mem_rr[mem_addr_rr[6:0]] <= mem_wdata_rr;
      if (mem_read_rr)  mem_rdata_rr <= mem_rr[mem_addr_rr[6:0]];
      if (mem_write_fp) mem_fp[mem_addr_fp[6:0]] <= mem_wdata_fp;
      if (mem_read_fp)  mem_rdata_fp <= mem_fp[mem_addr_fp[6:0]];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] flags_rr();
      return {24'd0, bus_rr.gnt0, bus_rr.gnt1, bus_rr.rvalid0, bus_rr.rvalid1,
              bus_rr.err0, bus_rr.err1, mem_write_rr, mem_read_rr};
   endfunction

   task automatic do_write(input logic port, input logic [31:0] a, input logic [31:0] d);
      if (port) begin req1 = 1'b1; we1 = 1'b1; addr1 = a; wdata1 = d; end
      else      begin req0 = 1'b1; we0 = 1'b1; addr0 = a; wdata0 = d; end
      step();
      check("wr_gnt", port ? {31'd0, bus_rr.gnt1} : {31'd0, bus_rr.gnt0}, 32'd1);
      check("wr_mem_write", {31'd0, mem_write_rr}, 32'd1);
      check("wr_mem_addr", mem_addr_rr, a);
      check("wr_mem_wdata", mem_wdata_rr, d);
      req0 = 1'b0; req1 = 1'b0;
      step();
      check("wr_pulse_end", flags_rr(), 32'd0);
   endtask

   task automatic do_read(input logic port, input logic [31:0] a, input logic [31:0] d);
      if (port) begin req1 = 1'b1; we1 = 1'b0; addr1 = a; end
      else      begin req0 = 1'b1; we0 = 1'b0; addr0 = a; end
      exp_q.push_back(d);
      step();
      check("rd_gnt", port ? {31'd0, bus_rr.gnt1} : {31'd0, bus_rr.gnt0}, 32'd1);
      check("rd_mem_read", {30'd0, mem_write_rr, mem_read_rr}, 32'd1);
      req0 = 1'b0; req1 = 1'b0;
      step();
      check("rd_rvalid", port ? {31'd0, bus_rr.rvalid1} : {31'd0, bus_rr.rvalid0}, 32'd1);
      check("rd_rdata", bus_rr.rdata, exp_q.pop_front());
      step();
      check("rd_idle", {30'd0, state_rr}, 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      step();
      step();
      check("reset_flags", flags_rr(), 32'd0);
      check("reset_state", {30'd0, state_rr}, 32'd0);
      check("reset_mem_addr", mem_addr_rr, 32'd0);
      check("reset_mem_wdata", mem_wdata_rr, 32'd0);
      reset = 1'b0;
      step();

      do_write(1'b0, 32'd5, 32'hDEADBEEF);
      do_read(1'b0, 32'd5, 32'hDEADBEEF);

      // Out of range write: consumed with err, memory untouched (word 0 aliases 128).
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'd128; wdata1 = 32'h0BAD0BAD;
      step();
      check("oor_flags", flags_rr(), 32'b0100_0100);
      check("oor_state", {30'd0, state_rr}, 32'd0);
      req1 = 1'b0;
      step();
      check("oor_pulse_end", flags_rr(), 32'd0);
      do_read(1'b0, 32'd0, 32'd0);

      // Reset sampled at the end of the ISSUE cycle abandons the read.
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
      step();
      check("rst_mid_gnt", {31'd0, bus_rr.gnt0}, 32'd1);
      req0 = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst_mid_flags", flags_rr(), 32'd0);
      check("rst_mid_state", {30'd0, state_rr}, 32'd0);
      check("rst_mid_addr", mem_addr_rr, 32'd0);
      step();
      check("rst_mid_no_rvalid", flags_rr(), 32'd0);
      do_read(1'b0, 32'd5, 32'hDEADBEEF);

      // Contention from a fresh reset so requester 0 takes the first tie.
      reset = 1'b1;
      step();
      reset = 1'b0;
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'd6;
      for (int c = 1; c <= 14; c++) begin
         step();
         check($sformatf("rr_gnt_c%0d", c), {30'd0, bus_rr.gnt0, bus_rr.gnt1},
               {30'd0, (c == 1 || c == 7), (c == 4 || c == 10 || c == 13)});
         check($sformatf("fp_gnt_c%0d", c), {30'd0, bus_fp.gnt0, bus_fp.gnt1},
               {30'd0, (c == 1 || c == 4 || c == 7 || c == 10), (c == 13)});
         if (c == 2 || c == 8)
            check($sformatf("rr_rdata_c%0d", c), {bus_rr.rvalid0, bus_rr.rdata[30:0]},
                  {1'b1, 31'h5EADBEEF});
         if (c == 5 || c == 11)
            check($sformatf("rr_rdata_c%0d", c), {31'd0, bus_rr.rvalid1}, 32'd1);
         if (c == 12) req0 = 1'b0;
         if (c == 13) req1 = 1'b0;
      end
      step();

      for (int i = 0; i < 3; i++) begin
         req1 = 1'b1; we1 = 1'b1; addr1 = i; wdata1 = 32'h11 * (i + 1);
         step();
         check($sformatf("b2b_gnt_%0d", i), {31'd0, bus_rr.gnt1}, 32'd1);
         check($sformatf("b2b_addr_%0d", i), mem_addr_rr, i);
         check($sformatf("b2b_wdata_%0d", i), mem_wdata_rr, 32'h11 * (i + 1));
         if (i == 2) req1 = 1'b0;
         step();
         check($sformatf("b2b_gap_%0d", i), {31'd0, bus_rr.gnt1}, 32'd0);
      end
      do_read(1'b1, 32'd0, 32'h11);
      do_read(1'b1, 32'd1, 32'h22);
      do_read(1'b1, 32'd2, 32'h33);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter that shares the single data memory between requester 0 (CPU load/store stage) and requester 1 (DMA/debug loader).
- Sequences every access onto the memory's control signals (addr, write_data, memWrite, memRead), observing the memory's one-cycle registered read latency.
- Returns read data to the winning requester, and flags out-of-range addresses without touching memory.

Parameters:
- ADDR_W, 32, address width on both requester ports and the memory port.
- DATA_W, 32, data width.
- DEPTH, 128, number of memory words; addresses >= DEPTH are rejected.
- FIXED_PRIO, 0, 0 = round-robin; 1 = requester 0 always wins ties.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  access request, one per requester.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  ADDR_W  word address.
- wdata0 / wdata1  in  DATA_W  write data.
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted.
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdata is valid for this requester.
- err0 / err1  out  1  one-cycle pulse: address out of range, request consumed.
- rdata  out  DATA_W  read data, shared by both requesters and qualified by rvalidN.
- mem_addr  out  ADDR_W  to memory addr.
- mem_wdata  out  DATA_W  to memory write_data.
- mem_write  out  1  to memory memWrite.
- mem_read  out  1  to memory memRead.
- mem_rdata  in  DATA_W  from memory read_data.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - State goes to IDLE.
  - All gnt/rvalid/err outputs and mem_write/mem_read clear to 0.
  - mem_addr and mem_wdata clear to 0.
  - last_grant clears to 1, so requester 0 wins the first tie.
- A reset during ISSUE or RDATA abandons the access: no rvalid or gnt follows, and any write not yet sampled by memory is dropped.
- FSM states:
  - IDLE: no access in progress.
  - ISSUE: memory controls driven for one cycle.
  - RDATA: read data being returned.
- IDLE, cycle T, at least one req high:
  - Winner chosen. If only one req is high, that requester wins. If both are high: with FIXED_PRIO=0, the requester not equal to last_grant wins; with FIXED_PRIO=1, requester 0 wins.
  - If the winner's addr >= DEPTH: errN=1 and gntN=1 in T+1, memory controls stay 0, state remains IDLE. last_grant updates normally.
  - Otherwise: registered at the T edge are mem_addr=addrN, mem_wdata=wdataN, mem_write=weN, mem_read=!weN, and gntN=1. State goes to ISSUE and last_grant becomes N.
- ISSUE, cycle T+1:
  - Memory samples the controls at the end of T+1.
  - Next state: write -> IDLE; read -> RDATA.
  - mem_write and mem_read return to 0 at the end of T+1, so each is high for exactly one cycle.
  - mem_addr and mem_wdata hold their values.
- RDATA, cycle T+2:
  - rdata = mem_rdata (combinational pass-through) and rvalidN=1.
  - Next state: IDLE.
- Latency and throughput:
  - Read: request at T, gnt at T+1, rvalid at T+2; next request is sampled at T+3 at the earliest.
  - Write: request at T, gnt at T+1; next request is sampled at T+2.
- Handshake rules:
  - A requester holds req/we/addr/wdata stable until it sees gnt, then deasserts req in the cycle after gnt or issues a new request.
  - req is ignored outside IDLE.
  - A req dropped before gnt is simply not served.
- rdata is undefined when no rvalid is high.
- At most one of gnt0/gnt1 is high in any cycle; the same holds for rvalid and err.
- mem_write and mem_read are never high together.
- addr is a word address; no byte-lane handling.

Test Plan:
- Single write then read: req0 we0=1 addr0=5 wdata0=0xDEADBEEF -> gnt0 at T+1, mem_write=1 for one cycle with mem_addr=5. Then read addr0=5 -> rvalid0 at T+2 with rdata=0xDEADBEEF.
- Contention, round-robin: req0 and req1 held high continuously (FIXED_PRIO=0), both reads -> grants alternate 0,1,0,1 with gnt spacing of 3 cycles; never two gnts in one cycle.
- Fixed priority: same stimulus with FIXED_PRIO=1 -> gnt0 on every arbitration while req0 is held; gnt1 only once req0 drops.
- Out of range: req1 we1=1 addr1=128 -> err1 and gnt1 at T+1; mem_write stays 0; memory word 0 is unchanged.
- Reset mid-read: read issued, reset=1 during the ISSUE cycle -> no rvalid, state IDLE, all outputs 0 the next cycle; a fresh read of addr 5 then still returns 0xDEADBEEF.
- Back-to-back writes from requester 1: addr1 = 0,1,2 with data 0x11,0x22,0x33 -> gnt1 every 2 cycles; readback returns 0x11, 0x22, 0x33.
